// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg: shared encodings for the multi-cycle MIPS-lite controller.
// Opcodes, ALUOp codes, FSM state encodings, datapath select codes and the
// control-vector bundle passed from the decode map to the top.

`ifndef ALU_OP_LENGTH
`define ALU_OP_LENGTH 3
`endif

package multicycle_ctrl_pkg;

  localparam int ALU_OP_W_C = `ALU_OP_LENGTH;

  // Opcodes, IR[31:26]
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  // ALUOp codes
  localparam logic [ALU_OP_W_C-1:0] ALU_ADD   = 3'b000;
  localparam logic [ALU_OP_W_C-1:0] ALU_SUB   = 3'b001;
  localparam logic [ALU_OP_W_C-1:0] ALU_OR    = 3'b010;
  localparam logic [ALU_OP_W_C-1:0] ALU_FUNCT = 3'b011;
  localparam logic [ALU_OP_W_C-1:0] ALU_XOR   = 3'b100;
  localparam logic [ALU_OP_W_C-1:0] ALU_AND   = 3'b101;
  localparam logic [ALU_OP_W_C-1:0] ALU_ADDI  = 3'b110;

  // pc_src / reg_dst / wb_sel codes
  localparam logic [1:0] PC_SRC_PC4  = 2'b00;
  localparam logic [1:0] PC_SRC_BR   = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP = 2'b10;

  localparam logic [1:0] REG_DST_RT = 2'b00;
  localparam logic [1:0] REG_DST_RD = 2'b01;
  localparam logic [1:0] REG_DST_RA = 2'b10;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_WB_ALU   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  // Raw per-state control vector; enables are qualified by mem_ready, zero
  // and stall in the top.
  typedef struct packed {
    logic                  mem_req;
    logic                  mem_we;
    logic                  ir_we;
    logic                  pc_we;
    logic                  reg_we;
    logic [1:0]            pc_src;
    logic [1:0]            reg_dst;
    logic [1:0]            wb_sel;
    logic                  alu_src;
    logic                  extend_op;
    logic [ALU_OP_W_C-1:0] alu_op;
  } ctrl_t;

  function automatic logic [ALU_OP_W_C-1:0] imm_alu_op(input logic [5:0] op);
    case (op)
      OP_ORI:  imm_alu_op = ALU_OR;
      OP_XORI: imm_alu_op = ALU_XOR;
      OP_ANDI: imm_alu_op = ALU_AND;
      OP_ADDI: imm_alu_op = ALU_ADDI;
      default: imm_alu_op = ALU_ADD;
    endcase
  endfunction

  // Only ADDI sign-extends among the immediate ALU ops.
  function automatic logic imm_sign_ext(input logic [5:0] op);
    imm_sign_ext = (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// multicycle_ctrl_decode: pure combinational map from {state, op_q} to the
// raw control vector. No handshake qualification happens here.

module multicycle_ctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  state_t     state_i,
  input  logic [5:0] op_q_i,
  output ctrl_t      ctrl_o
);

  // Per-state control vector; every field not named in a state stays 0.
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_req = 1'b1;
        ctrl_o.ir_we   = 1'b1;
        ctrl_o.pc_we   = 1'b1;
        ctrl_o.pc_src  = PC_SRC_PC4;
      end
      S_EXEC_R: begin
        ctrl_o.alu_op  = ALU_FUNCT;
        ctrl_o.alu_src = 1'b0;
      end
      S_EXEC_I: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.alu_op    = imm_alu_op(op_q_i);
        ctrl_o.extend_op = imm_sign_ext(op_q_i);
      end
      S_WB_ALU: begin
        ctrl_o.reg_we = 1'b1;
        ctrl_o.wb_sel = WB_SEL_ALU;
        // ALU controls stay as in EXEC so the result is stable during write.
        if (op_q_i == OP_R) begin
          ctrl_o.reg_dst = REG_DST_RD;
          ctrl_o.alu_op  = ALU_FUNCT;
        end else begin
          ctrl_o.reg_dst   = REG_DST_RT;
          ctrl_o.alu_src   = 1'b1;
          ctrl_o.alu_op    = imm_alu_op(op_q_i);
          ctrl_o.extend_op = imm_sign_ext(op_q_i);
        end
      end
      S_MEM_ADDR: begin
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.extend_op = 1'b1;
      end
      S_MEM_RD: begin
        ctrl_o.mem_req = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_o.mem_req = 1'b1;
        ctrl_o.mem_we  = 1'b1;
      end
      S_WB_MEM: begin
        ctrl_o.reg_we  = 1'b1;
        ctrl_o.wb_sel  = WB_SEL_MEM;
        ctrl_o.reg_dst = REG_DST_RT;
      end
      S_BRANCH: begin
        ctrl_o.alu_op  = ALU_SUB;
        ctrl_o.alu_src = 1'b0;
        ctrl_o.pc_we   = 1'b1;
        ctrl_o.pc_src  = PC_SRC_BR;
      end
      S_JUMP: begin
        ctrl_o.pc_we   = 1'b1;
        ctrl_o.pc_src  = PC_SRC_JUMP;
        ctrl_o.reg_we  = 1'b1;
        ctrl_o.reg_dst = REG_DST_RA;
        ctrl_o.wb_sel  = WB_SEL_PC4;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle MIPS-lite sequencer (FETCH/DECODE/EXEC/MEM/WB).
// Optional memory wait timeout enabled by defining MULTICYCLE_WAIT_TIMEOUT_EN,
// which adds the mem_timeout output and the MAX_WAIT parameter.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// FETCH    | read instruction; load IR and PC+4 on mem_ready
// DECODE   | latch opcode, branch to the per-class sequence
// EXEC_R   | R-type ALU operation
// EXEC_I   | immediate ALU operation
// WB_ALU   | write ALU result to rd (R) or rt (I)
// MEM_ADDR | compute base + sign-extended offset
// MEM_RD   | load access, wait for mem_ready
// MEM_WR   | store access, wait for mem_ready
// WB_MEM   | write load data to rt
// BRANCH   | BEQ compare, PC <= target when zero
// JUMP     | JAL: PC <= target, $31 <= pc+4
// TRAP     | illegal opcode or timeout; held until rst

module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int ALU_OP_W = `ALU_OP_LENGTH
`ifdef MULTICYCLE_WAIT_TIMEOUT_EN
  , parameter int MAX_WAIT = 15
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          op,
  input  logic                zero,
  input  logic                mem_ready,
  input  logic                stall,
  output logic                pc_we,
  output logic [1:0]          pc_src,
  output logic                ir_we,
  output logic                mem_req,
  output logic                mem_we,
  output logic                reg_we,
  output logic [1:0]          reg_dst,
  output logic [1:0]          wb_sel,
  output logic                alu_src,
  output logic                extend_op,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                illegal_op,
  output logic [3:0]          state_o
`ifdef MULTICYCLE_WAIT_TIMEOUT_EN
  , output logic              mem_timeout
`endif
);

  state_t     state_q, state_d;
  logic [5:0] op_q;
  logic       illegal_q;
  ctrl_t      ctrl;
  logic       pc_qual;
  logic       ir_qual;
  logic       wait_hit;

  multicycle_ctrl_decode u_decode (
    .state_i (state_q),
    .op_q_i  (op_q),
    .ctrl_o  (ctrl)
  );

`ifdef MULTICYCLE_WAIT_TIMEOUT_EN
  logic [3:0] wait_cnt_q;
  logic       timeout_q;

  assign wait_hit = !stall && ctrl.mem_req && !mem_ready
                    && (wait_cnt_q == 4'(MAX_WAIT - 1));

  // Wait counter: restarts on every state change, counts unstalled waits.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= 4'd0;
      timeout_q  <= 1'b0;
    end else begin
      if (state_d != state_q) begin
        wait_cnt_q <= 4'd0;
      end else if (!stall && ctrl.mem_req && !mem_ready) begin
        wait_cnt_q <= wait_cnt_q + 4'd1;
      end
      if (wait_hit) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign mem_timeout = !rst && timeout_q;
`else
  assign wait_hit = 1'b0;
`endif

  // Next-state logic; a stall freezes every transition.
  always_comb begin
    state_d = state_q;
    if (!stall) begin
      case (state_q)
        S_FETCH:  if (mem_ready) state_d = S_DECODE;
        S_DECODE: begin
          case (op)
            OP_R:                             state_d = S_EXEC_R;
            OP_ORI, OP_XORI, OP_ANDI, OP_ADDI: state_d = S_EXEC_I;
            OP_LW, OP_SW:                     state_d = S_MEM_ADDR;
            OP_BEQ:                           state_d = S_BRANCH;
            OP_JAL:                           state_d = S_JUMP;
            default:                          state_d = S_TRAP;
          endcase
        end
        S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
        S_MEM_ADDR: state_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD: if (mem_ready) state_d = S_WB_MEM;
        S_MEM_WR: if (mem_ready) state_d = S_FETCH;
        S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: state_d = S_FETCH;
        S_TRAP:   state_d = S_TRAP;
        default:  state_d = S_FETCH;
      endcase
      if (wait_hit) state_d = S_TRAP;
    end
  end

  // FSM state, latched opcode and sticky illegal-opcode flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      op_q      <= 6'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE && !stall) begin
        op_q <= op;
        if (state_d == S_TRAP) illegal_q <= 1'b1;
      end
    end
  end

  // FETCH enables wait on the handshake; BRANCH writes PC only when taken.
  always_comb begin
    pc_qual = 1'b1;
    ir_qual = 1'b1;
    if (state_q == S_FETCH) begin
      pc_qual = mem_ready;
      ir_qual = mem_ready;
    end else if (state_q == S_BRANCH) begin
      pc_qual = zero;
    end
  end

  assign pc_we      = !rst && !stall && ctrl.pc_we && pc_qual;
  assign ir_we      = !rst && !stall && ctrl.ir_we && ir_qual;
  assign reg_we     = !rst && !stall && ctrl.reg_we;
  assign mem_we     = !rst && !stall && ctrl.mem_we;
  assign mem_req    = !rst && ctrl.mem_req;
  assign pc_src     = rst ? 2'b00 : ctrl.pc_src;
  assign reg_dst    = rst ? 2'b00 : ctrl.reg_dst;
  assign wb_sel     = rst ? 2'b00 : ctrl.wb_sel;
  assign alu_src    = !rst && ctrl.alu_src;
  assign extend_op  = !rst && ctrl.extend_op;
  assign alu_op     = rst ? '0 : ctrl.alu_op;
  assign illegal_op = !rst && illegal_q;
  assign state_o    = rst ? 4'd0 : state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: cycle-by-cycle vector table plus wait-handshake sequences.

module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       stall = 1'b0;
  logic       pc_we, ir_we, mem_req, mem_we, reg_we, alu_src, extend_op, illegal_op;
  logic [1:0] pc_src, reg_dst, wb_sel;
  logic [2:0] alu_op;
  logic [3:0] state_o;
`ifdef MULTICYCLE_WAIT_TIMEOUT_EN
  logic       mem_timeout;
`endif

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .stall      (stall),
    .pc_we      (pc_we),
    .pc_src     (pc_src),
    .ir_we      (ir_we),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .reg_we     (reg_we),
    .reg_dst    (reg_dst),
    .wb_sel     (wb_sel),
    .alu_src    (alu_src),
    .extend_op  (extend_op),
    .alu_op     (alu_op),
    .illegal_op (illegal_op),
    .state_o    (state_o)
`ifdef MULTICYCLE_WAIT_TIMEOUT_EN
    , .mem_timeout (mem_timeout)
`endif
  );

  typedef struct packed {
    logic [3:0] st;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       ir_we;
    logic       mem_req;
    logic       mem_we;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] wb_sel;
    logic       alu_src;
    logic       ext;
    logic [2:0] alu_op;
    logic       ill;
  } outs_t;

  typedef struct packed {
    logic       rst;
    logic       stall;
    logic       rdy;
    logic       zero;
    logic [5:0] op;
    outs_t      exp;
  } vec_t;

  outs_t act;
  assign act = {state_o, pc_we, pc_src, ir_we, mem_req, mem_we, reg_we,
                reg_dst, wb_sel, alu_src, extend_op, alu_op, illegal_op};

  vec_t vecs[$];
  int   n_pass = 0;
  int   n_total = 0;

  function automatic outs_t o(input logic [3:0] st, input logic pcwe, input logic [1:0] pcs,
                              input logic irwe, input logic mreq, input logic mwe,
                              input logic rwe, input logic [1:0] rdst, input logic [1:0] wsel,
                              input logic asrc, input logic ext, input logic [2:0] aop,
                              input logic ill);
    outs_t r;
    r = {st, pcwe, pcs, irwe, mreq, mwe, rwe, rdst, wsel, asrc, ext, aop, ill};
    return r;
  endfunction

  task automatic add(input logic r, input logic s, input logic rd, input logic z,
                     input logic [5:0] opc, input outs_t e);
    vec_t v;
    v.rst = r; v.stall = s; v.rdy = rd; v.zero = z; v.op = opc; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input outs_t a, input outs_t e);
    n_total++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got st=%0d bundle=%b, want st=%0d bundle=%b",
                  name, a.st, a, e.st, e);
  endtask

  task automatic chk_bit(input string name, input logic a, input logic e);
    n_total++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %b, want %b", name, a, e);
  endtask

  localparam logic [5:0] R = 6'b000000, ORI = 6'b001101, LW = 6'b100011, SW = 6'b101011,
                         BEQ = 6'b000100, JAL = 6'b000011, ADDI = 6'b001000, BAD = 6'b111111;

  outs_t NONE, FET, FETW;

  initial begin
    NONE = o(0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 3'b000, 0);
    FET  = o(0, 1, 2'b00, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 3'b000, 0);
    FETW = o(0, 0, 2'b00, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 3'b000, 0);

    //    rst stall rdy zero op    expected
    add(1, 0, 1, 0, R,    NONE);
    // ADDI
    add(0, 0, 1, 0, R,    FET);
    add(0, 0, 1, 0, ADDI, o(1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 3'b000, 0));
    add(0, 0, 1, 0, R,    o(3, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1, 3'b110, 0));
    add(0, 0, 1, 0, R,    o(4, 0, 2'b00, 0, 0, 0, 1, 2'b00, 2'b00, 1, 1, 3'b110, 0));
    // ORI
    add(0, 0, 1, 0, R,    FET);
    add(0, 0, 1, 0, ORI,  o(1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 3'b000, 0));
    add(0, 0, 1, 0, R,    o(3, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 3'b010, 0));
    add(0, 0, 1, 0, R,    o(4, 0, 2'b00, 0, 0, 0, 1, 2'b00, 2'b00, 1, 0, 3'b010, 0));
    // R-type with a 3-cycle stall in EXEC_R
    add(0, 0, 1, 0, R,    FET);
    add(0, 0, 1, 0, R,    o(1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 3'b000, 0));
    add(0, 1, 1, 0, R,    o(2, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 3'b011, 0));
    add(0, 1, 1, 0, R,    o(2, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 3'b011, 0));
    add(0, 1, 1, 0, R,    o(2, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 3'b011, 0));
    add(0, 0, 1, 0, R,    o(2, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 3'b011, 0));
    add(0, 0, 1, 0, R,    o(4, 0, 2'b00, 0, 0, 0, 1, 2'b01, 2'b00, 0, 0, 3'b011, 0));
    // LW with two wait cycles in MEM_RD
    add(0, 0, 1, 0, R,    FET);
    add(0, 0, 1, 0, LW,   o(1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 3'b000, 0));
    add(0, 0, 1, 0, R,    o(5, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1, 3'b000, 0));
    add(0, 0, 0, 0, R,    o(6, 0, 2'b00, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 3'b000, 0));
    add(0, 0, 0, 0, R,    o(6, 0, 2'b00, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 3'b000, 0));
    add(0, 0, 1, 0, R,    o(6, 0, 2'b00, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 3'b000, 0));
    add(0, 0, 1, 0, R,    o(8, 0, 2'b00, 0, 0, 0, 1, 2'b00, 2'b01, 0, 0, 3'b000, 0));
    // BEQ taken, then not taken
    add(0, 0, 1, 0, R,    FET);
    add(0, 0, 1, 0, BEQ,  o(1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 3'b000, 0));
    add(0, 0, 1, 1, R,    o(9, 1, 2'b01, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 3'b001, 0));
    add(0, 0, 1, 0, R,    FET);
    add(0, 0, 1, 0, BEQ,  o(1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 3'b000, 0));
    add(0, 0, 1, 0, R,    o(9, 0, 2'b01, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 3'b001, 0));
    // JAL
    add(0, 0, 1, 0, R,    FET);
    add(0, 0, 1, 0, JAL,  o(1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 3'b000, 0));
    add(0, 0, 1, 0, R,    o(10, 1, 2'b10, 0, 0, 0, 1, 2'b10, 2'b10, 0, 0, 3'b000, 0));
    // SW: wait, stall+ready (stall wins), then rst in MEM_WR
    add(0, 0, 1, 0, R,    FET);
    add(0, 0, 1, 0, SW,   o(1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 3'b000, 0));
    add(0, 0, 1, 0, R,    o(5, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1, 3'b000, 0));
    add(0, 0, 0, 0, R,    o(7, 0, 2'b00, 0, 1, 1, 0, 2'b00, 2'b00, 0, 0, 3'b000, 0));
    add(0, 1, 1, 0, R,    o(7, 0, 2'b00, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 3'b000, 0));
    add(1, 0, 1, 0, R,    NONE);
    add(0, 0, 0, 0, R,    FETW);
    // FETCH with stall+ready held, then SW with zero wait
    add(0, 1, 1, 0, R,    FETW);
    add(0, 0, 1, 0, R,    FET);
    add(0, 0, 1, 0, SW,   o(1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 3'b000, 0));
    add(0, 0, 1, 0, R,    o(5, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1, 3'b000, 0));
    add(0, 0, 1, 0, R,    o(7, 0, 2'b00, 0, 1, 1, 0, 2'b00, 2'b00, 0, 0, 3'b000, 0));
    // Illegal opcode -> sticky TRAP, cleared by rst
    add(0, 0, 1, 0, R,    FET);
    add(0, 0, 1, 0, BAD,  o(1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 3'b000, 0));
    add(0, 0, 1, 0, R,    o(11, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 3'b000, 1));
    add(0, 0, 1, 0, JAL,  o(11, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 3'b000, 1));
    add(1, 0, 1, 0, R,    NONE);
    add(0, 0, 0, 0, R,    FETW);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; stall = vecs[i].stall; mem_ready = vecs[i].rdy;
      zero = vecs[i].zero; op = vecs[i].op;
      #1;
      chk($sformatf("vec%0d", i), act, vecs[i].exp);
    end

    // Long memory wait in FETCH after a fresh reset.
    @(negedge clk);
    rst = 1'b1; stall = 1'b0; mem_ready = 1'b0; op = R;
    @(negedge clk);
    rst = 1'b0;
    repeat (14) @(negedge clk);
    #1;
    chk("wait14_fetch", act, FETW);
    @(negedge clk);
    #1;
`ifdef MULTICYCLE_WAIT_TIMEOUT_EN
    chk("wait15_trap", act, NONE | o(11, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 3'b000, 0));
    chk_bit("mem_timeout_set", mem_timeout, 1'b1);
    mem_ready = 1'b1;
    @(negedge clk);
    #1;
    chk_bit("mem_timeout_sticky", mem_timeout, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_bit("mem_timeout_cleared", mem_timeout, 1'b0);
`else
    chk("wait15_fetch", act, FETW);
    repeat (10) @(negedge clk);
    mem_ready = 1'b1;
    #1;
    chk("wait_release", act, FET);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk_bit("after_wait_decode", state_o == 4'd1, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
